instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
Producer side of the instruction FIFO. It generates sequential fetch addresses, issues them to the instruction cache, and enqueues each returned instruction together with its PC into the downstream instruction FIFO. Flow control is credit-based on FIFO slots. A restart from a branch or rollback redirects the PC and discards stale in-flight cache responses.

Parameters:
ADDR_WIDTH, 32, width of PC and cache address
INST_WIDTH, 32, width of one instruction word
RESET_PC, 0, PC loaded at reset
FIFO_DEPTH, 2, downstream FIFO slot count; initial and maximum credit value
MAX_OUTSTANDING, 2, maximum issued but unreturned cache requests (power of 2)

Ports:
clk  in  1  clock
reset_n  in  1  reset, asynchronous, active-low
restart_i  in  1  redirect fetch; same cycle as the downstream FIFO flush
restart_pc_i  in  ADDR_WIDTH  new PC; bits [1:0] ignored and forced to 0
halt_i  in  1  stop issuing new fetches until the next restart
icache_request_o  out  1  fetch request valid
icache_addr_o  out  ADDR_WIDTH  fetch address (current PC)
icache_accept_i  in  1  cache accepts the request this cycle
icache_valid_i  in  1  response valid; responses return in issue order
icache_data_i  in  INST_WIDTH  instruction word
enqueue_o  out  1  push into the downstream FIFO
value_o  out  ADDR_WIDTH+INST_WIDTH  {pc, instruction}
dequeue_i  in  1  downstream FIFO popped one entry; returns one credit

Behaviour:
- Reset (async, reset_n=0):
  - pc=RESET_PC, credits=FIFO_DEPTH, outstanding=0, discard=0, state=RUN.
  - icache_request_o=0, enqueue_o=0, value_o=0, PC queue empty.
- States:
  - RUN: issuing allowed.
  - HALTED: no issue. In-flight responses still complete and enqueue normally.
  - RUN->HALTED on halt_i with no restart_i.
  - Any state -> RUN on restart_i. Restart has priority over halt.
- Issue rule: icache_request_o = (state==RUN) && credits>0 && outstanding<MAX_OUTSTANDING && !restart_i. This is combinational from registered state and restart_i.
- icache_addr_o = pc.
- On icache_request_o && icache_accept_i:
  - pc <= pc+4, wrapping modulo 2^ADDR_WIDTH.
  - credits decrements; outstanding increments.
  - The issuing pc is pushed into the PC queue.
- Response: icache_valid_i decrements outstanding.
  - If discard>0: discard decrements and nothing is enqueued.
  - Otherwise pop the PC queue. Next cycle enqueue_o=1 and value_o={popped pc, icache_data_i}. Latency is exactly 1 cycle from icache_valid_i.
- enqueue_o is registered and high for one cycle per live response. value_o holds its last value when enqueue_o=0.
- Credits: dequeue_i increments credits.
  - Issue and dequeue in the same cycle leave credits unchanged.
  - credits never exceeds FIFO_DEPTH. Ensured by construction, checked by assertion.
- Restart cycle:
  - pc <= {restart_pc_i[ADDR_WIDTH-1:2],2'b00}; credits <= FIFO_DEPTH; PC queue cleared.
  - discard <= outstanding - icache_valid_i. The response arriving this cycle is itself dropped.
  - outstanding <= outstanding - icache_valid_i.
  - Pending enqueue register cleared, so enqueue_o=0 next cycle. dequeue_i is ignored this cycle.
- After restart:
  - Issue may resume next cycle even while discard>0.
  - Outstanding includes the to-be-discarded requests, so the in-order return guarantees stale responses drain first.
- Simultaneous issue and response in one cycle: outstanding unchanged. The PC queue pushes and pops in the same cycle.
- Simulation-only checks (terminate via $display/$finish):
  - icache_valid_i with outstanding==0.
  - dequeue_i with credits==FIFO_DEPTH outside a restart cycle.

Decomposition:
- Shared package holds:
  - The state encoding (RUN=1'b0, HALTED=1'b1).
  - The fetch packet field offsets within value_o (pc in the upper bits, instruction in the lower bits).
  - The PC increment constant 4.
- Sub-module fetch_pc_queue: in-order queue of MAX_OUTSTANDING x ADDR_WIDTH.
  - Ports: push, pop, clear, data in/out.
  - Circular read/write pointers with an extra wrap bit.
  - Async active-low reset.

Test Plan:
1. Reset with RESET_PC=0x100 and a 1-cycle cache, no dequeue.
   - Requests go to 0x100 and 0x104, then icache_request_o stays 0 (credits=0).
   - Exactly two enqueues: {0x100,d0} and {0x104,d1}.
2. Continue test 1 by pulsing dequeue_i once.
   - Next issue is 0x108 in the following cycle; credits return to 0 after the accept.
3. Hold icache_accept_i=0 for 5 cycles.
   - icache_request_o stays 1 and icache_addr_o stays constant.
   - pc, credits and outstanding are unchanged until accept.
4. Two requests outstanding (0x200, 0x204), then restart_i with restart_pc_i=0x403.
   - Next request goes to 0x400.
   - Both old responses are dropped with no enqueue.
   - First enqueue is {0x400,data}.
5. Restart in the same cycle that icache_valid_i returns the 0x200 data.
   - That response is not enqueued; discard=1; enqueue_o=0 the next cycle.
6. halt_i asserted with one request outstanding.
   - That response is still enqueued.
   - No further requests are issued until restart_i, after which fetch resumes at restart_pc_i.

Source files
------------

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: state encoding,
// fetch packet field layout and the sequential PC step.
package instruction_fetch_unit_pkg;

   typedef enum logic {
      RUN    = 1'b0,
      HALTED = 1'b1
   } fetch_state_e;

   localparam int unsigned PC_INCREMENT   = 4;
   localparam int unsigned INST_FIELD_LSB = 0;

   // The PC sits directly above the instruction word in a fetch packet
   function automatic int unsigned pc_field_lsb(input int unsigned inst_width);
      return inst_width;
   endfunction

endpackage

// File: rtl/fetch_pc_queue.sv
// In-order queue holding the PC of every issued, not yet returned fetch.
// Pointers carry an extra wrap bit so a full queue is distinguishable from empty.
module fetch_pc_queue
   import instruction_fetch_unit_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DEPTH      = 2
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  push,
   input  logic                  pop,
   input  logic                  clear,
   input  logic [ADDR_WIDTH-1:0] push_data,
   output logic [ADDR_WIDTH-1:0] head_data
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [ADDR_WIDTH-1:0] mem [2**PW];
   logic [PW:0]           wr_ptr;
   logic [PW:0]           rd_ptr;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !clear) mem[wr_ptr[PW-1:0]] <= push_data;
   end

   assign head_data = mem[rd_ptr[PW-1:0]];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch address generator and instruction FIFO producer with credit-based
// flow control; a restart redirects the PC and drops stale cache responses.
module instruction_fetch_unit
   import instruction_fetch_unit_pkg::*;
#(
   parameter int                    ADDR_WIDTH      = 32,
   parameter int                    INST_WIDTH      = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC        = '0,
   parameter int                    FIFO_DEPTH      = 2,
   parameter int                    MAX_OUTSTANDING = 2
) (
   input  logic                             clk,
   input  logic                             reset_n,
   input  logic                             restart_i,
   input  logic [ADDR_WIDTH-1:0]            restart_pc_i,
   input  logic                             halt_i,
   output logic                             icache_request_o,
   output logic [ADDR_WIDTH-1:0]            icache_addr_o,
   input  logic                             icache_accept_i,
   input  logic                             icache_valid_i,
   input  logic [INST_WIDTH-1:0]            icache_data_i,
   output logic                             enqueue_o,
   output logic [ADDR_WIDTH+INST_WIDTH-1:0] value_o,
   input  logic                             dequeue_i
);

   localparam int CW     = $clog2(FIFO_DEPTH + 1);
   localparam int OW     = $clog2(MAX_OUTSTANDING + 1);
   localparam int PC_LSB = pc_field_lsb(INST_WIDTH);

   localparam logic [CW-1:0]         FULL_CREDITS = CW'(FIFO_DEPTH);
   localparam logic [OW-1:0]         MAX_OUT      = OW'(MAX_OUTSTANDING);
   localparam logic [ADDR_WIDTH-1:0] WORD_MASK    = ~ADDR_WIDTH'(3);

   fetch_state_e                     state;
   fetch_state_e                     next_state;
   logic [ADDR_WIDTH-1:0]            pc;
   logic [CW-1:0]                    credits;
   logic [OW-1:0]                    outstanding;
   logic [OW-1:0]                    discard;
   logic                             enqueue_q;
   logic [ADDR_WIDTH+INST_WIDTH-1:0] value_q;
   logic [ADDR_WIDTH-1:0]            queue_head;
   logic                             fire;
   logic                             live;
   logic [OW-1:0]                    valid_ext;

   // Issue is gated by reset so no request escapes while the unit is held in reset
   assign icache_request_o = reset_n && (state == RUN) && (credits != '0)
                             && (outstanding < MAX_OUT) && !restart_i;
   assign icache_addr_o    = pc;
   assign fire             = icache_request_o && icache_accept_i;
   assign live             = icache_valid_i && (discard == '0) && !restart_i;
   assign valid_ext        = OW'(icache_valid_i);
   assign enqueue_o        = enqueue_q;
   assign value_o          = value_q;

   fetch_pc_queue #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DEPTH      (MAX_OUTSTANDING)
   ) u_pc_queue (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (fire),
      .pop       (live),
      .clear     (restart_i),
      .push_data (pc),
      .head_data (queue_head)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= RUN;
      else          state <= next_state;
   end

   always_comb begin
      next_state = state;
      if (restart_i)   next_state = RUN;
      else if (halt_i) next_state = HALTED;
   end

   // Restart wins over everything: stale in-flight requests become discards
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc          <= RESET_PC;
         credits     <= FULL_CREDITS;
         outstanding <= '0;
         discard     <= '0;
         enqueue_q   <= 1'b0;
         value_q     <= '0;
      end else if (restart_i) begin
         pc          <= restart_pc_i & WORD_MASK;
         credits     <= FULL_CREDITS;
         outstanding <= outstanding - valid_ext;
         discard     <= outstanding - valid_ext;
         enqueue_q   <= 1'b0;
      end else begin
         if (fire) pc <= pc + ADDR_WIDTH'(PC_INCREMENT);
         case ({fire, dequeue_i})
            2'b10:   credits <= credits - 1'b1;
            2'b01:   credits <= credits + 1'b1;
            default: credits <= credits;
         endcase
         case ({fire, icache_valid_i})
            2'b10:   outstanding <= outstanding + 1'b1;
            2'b01:   outstanding <= outstanding - 1'b1;
            default: outstanding <= outstanding;
         endcase
         if (icache_valid_i && (discard != '0)) discard <= discard - 1'b1;
         enqueue_q <= live;
         if (live) begin
            value_q[PC_LSB +: ADDR_WIDTH]         <= queue_head;
            value_q[INST_FIELD_LSB +: INST_WIDTH] <= icache_data_i;
         end
      end
   end

   a_no_orphan_response: assert property (@(posedge clk) disable iff (!reset_n)
      !(icache_valid_i && (outstanding == '0)));
   a_no_credit_overflow: assert property (@(posedge clk) disable iff (!reset_n)
      !(dequeue_i && !restart_i && (credits == FULL_CREDITS)));
   a_credit_bound: assert property (@(posedge clk) disable iff (!reset_n)
      credits <= FULL_CREDITS);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: sequential fetch, credit stall,
// accept backpressure, restart with stale-response discard, and halt.
module tb_instruction_fetch_unit;

   localparam int AW = 32;
   localparam int IW = 32;

   logic          clk;
   logic          reset_n;
   logic          restart;
   logic [AW-1:0] restart_pc;
   logic          halt;
   logic          request;
   logic [AW-1:0] addr;
   logic          accept;
   logic          valid;
   logic [IW-1:0] data;
   logic          enqueue;
   logic [AW+IW-1:0] value;
   logic          dequeue;

   int error_count = 0;
   int check_count = 0;

   instruction_fetch_unit #(
      .ADDR_WIDTH      (AW),
      .INST_WIDTH      (IW),
      .RESET_PC        (32'h100),
      .FIFO_DEPTH      (2),
      .MAX_OUTSTANDING (2)
   ) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .restart_i        (restart),
      .restart_pc_i     (restart_pc),
      .halt_i           (halt),
      .icache_request_o (request),
      .icache_addr_o    (addr),
      .icache_accept_i  (accept),
      .icache_valid_i   (valid),
      .icache_data_i    (data),
      .enqueue_o        (enqueue),
      .value_o          (value),
      .dequeue_i        (dequeue)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      check_count++;
      if (observed !== expected) begin
         error_count++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   // Inputs change one time unit after a clock edge, then settle before checks
   task automatic applyStimulus(input logic rs, input logic [AW-1:0] rs_pc, input logic hl,
                                input logic acc, input logic vld, input logic [IW-1:0] dat,
                                input logic deq);
      restart    = rs;
      restart_pc = rs_pc;
      halt       = hl;
      accept     = acc;
      valid      = vld;
      data       = dat;
      dequeue    = deq;
      #1;
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_n = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_request", 64'(request), 64'd0);
      checkOutput("reset_enqueue", 64'(enqueue), 64'd0);
      checkOutput("reset_value",   value, 64'd0);

      // Sequential fetch from RESET_PC until credits run out
      reset_n = 1'b1;
      applyStimulus(0, 0, 0, 1, 0, 0, 0);
      checkOutput("t1_req0",  64'(request), 64'd1);
      checkOutput("t1_addr0", 64'(addr), 64'h100);
      advance();
      applyStimulus(0, 0, 0, 1, 1, 32'hA000_0000, 0);
      checkOutput("t1_req1",  64'(request), 64'd1);
      checkOutput("t1_addr1", 64'(addr), 64'h104);
      advance();
      applyStimulus(0, 0, 0, 1, 1, 32'hA000_0001, 0);
      checkOutput("t1_enq0",   64'(enqueue), 64'd1);
      checkOutput("t1_value0", value, {32'h100, 32'hA000_0000});
      checkOutput("t1_nocred", 64'(request), 64'd0);
      advance();
      applyStimulus(0, 0, 0, 1, 0, 0, 0);
      checkOutput("t1_enq1",   64'(enqueue), 64'd1);
      checkOutput("t1_value1", value, {32'h104, 32'hA000_0001});
      checkOutput("t1_nocred2", 64'(request), 64'd0);
      advance();

      // One dequeue returns one credit
      applyStimulus(0, 0, 0, 1, 0, 0, 1);
      checkOutput("t2_enq_idle", 64'(enqueue), 64'd0);
      checkOutput("t2_value_hold", value, {32'h104, 32'hA000_0001});
      checkOutput("t2_req_before", 64'(request), 64'd0);
      advance();

      // Accept backpressure keeps the request and address stable
      for (int i = 0; i < 5; i++) begin
         applyStimulus(0, 0, 0, 0, 0, 0, 0);
         checkOutput("t3_req_held",  64'(request), 64'd1);
         checkOutput("t3_addr_held", 64'(addr), 64'h108);
         advance();
      end
      applyStimulus(0, 0, 0, 1, 0, 0, 0);
      checkOutput("t3_req_accept",  64'(request), 64'd1);
      checkOutput("t3_addr_accept", 64'(addr), 64'h108);
      advance();
      applyStimulus(0, 0, 0, 0, 1, 32'hA000_0002, 0);
      checkOutput("t2_credits_zero", 64'(request), 64'd0);
      checkOutput("t3_addr_next",    64'(addr), 64'h10C);
      advance();
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("t3_enq",   64'(enqueue), 64'd1);
      checkOutput("t3_value", value, {32'h108, 32'hA000_0002});
      advance();

      // Two outstanding at 0x200/0x204, then redirect to 0x403
      applyStimulus(1, 32'h200, 0, 0, 0, 0, 0);
      checkOutput("t4_req_restart", 64'(request), 64'd0);
      advance();
      applyStimulus(0, 0, 0, 1, 0, 0, 0);
      checkOutput("t4_addr200", 64'(addr), 64'h200);
      advance();
      applyStimulus(0, 0, 0, 1, 0, 0, 0);
      checkOutput("t4_addr204", 64'(addr), 64'h204);
      advance();
      applyStimulus(1, 32'h403, 0, 1, 0, 0, 0);
      checkOutput("t4_req_restart2", 64'(request), 64'd0);
      advance();
      applyStimulus(0, 0, 0, 0, 1, 32'hDEAD_0000, 0);
      checkOutput("t4_req_outfull", 64'(request), 64'd0);
      advance();
      applyStimulus(0, 0, 0, 1, 1, 32'hDEAD_0001, 0);
      checkOutput("t4_drop0",   64'(enqueue), 64'd0);
      checkOutput("t4_req400",  64'(request), 64'd1);
      checkOutput("t4_addr400", 64'(addr), 64'h400);
      advance();
      applyStimulus(0, 0, 0, 0, 1, 32'hA000_0004, 0);
      checkOutput("t4_drop1", 64'(enqueue), 64'd0);
      advance();
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("t4_enq",   64'(enqueue), 64'd1);
      checkOutput("t4_value", value, {32'h400, 32'hA000_0004});
      advance();

      // Restart in the same cycle the 0x200 response returns
      applyStimulus(1, 32'h200, 0, 0, 0, 0, 0);
      advance();
      applyStimulus(0, 0, 0, 1, 0, 0, 0);
      checkOutput("t5_addr200", 64'(addr), 64'h200);
      advance();
      applyStimulus(0, 0, 0, 1, 0, 0, 0);
      checkOutput("t5_addr204", 64'(addr), 64'h204);
      advance();
      applyStimulus(1, 32'h300, 0, 0, 1, 32'hDEAD_0002, 0);
      advance();
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("t5_enq_after_restart", 64'(enqueue), 64'd0);
      checkOutput("t5_req300",  64'(request), 64'd1);
      checkOutput("t5_addr300", 64'(addr), 64'h300);
      advance();
      applyStimulus(0, 0, 0, 0, 1, 32'hDEAD_0003, 0);
      advance();
      applyStimulus(0, 0, 0, 1, 0, 0, 0);
      checkOutput("t5_stale_drop", 64'(enqueue), 64'd0);
      checkOutput("t5_addr300b",   64'(addr), 64'h300);
      advance();

      // Halt with the 0x300 fetch still in flight
      applyStimulus(0, 0, 1, 0, 0, 0, 0);
      advance();
      applyStimulus(0, 0, 0, 1, 1, 32'hA000_0005, 0);
      checkOutput("t6_req_halted", 64'(request), 64'd0);
      advance();
      applyStimulus(0, 0, 0, 1, 0, 0, 0);
      checkOutput("t6_enq",   64'(enqueue), 64'd1);
      checkOutput("t6_value", value, {32'h300, 32'hA000_0005});
      checkOutput("t6_req_halted2", 64'(request), 64'd0);
      advance();
      applyStimulus(0, 0, 0, 1, 0, 0, 0);
      checkOutput("t6_req_halted3", 64'(request), 64'd0);
      checkOutput("t6_enq_idle",    64'(enqueue), 64'd0);
      advance();
      applyStimulus(1, 32'h500, 1, 1, 0, 0, 0);
      checkOutput("t6_req_restart", 64'(request), 64'd0);
      advance();
      applyStimulus(0, 0, 0, 1, 0, 0, 0);
      checkOutput("t6_req_resume",  64'(request), 64'd1);
      checkOutput("t6_addr_resume", 64'(addr), 64'h500);
      advance();

      $display("Result: errors=%0d of %0d checks", error_count, check_count);
      $finish;
   end

endmodule
